// File: rtl/pe_uop_sequencer.sv
// Per-window micro-op issuer for a single PE: flush, K MAC uops, optional bias uop, output enable.
// Fetches operands from two synchronous-read buffers and returns the (optionally ReLU'd) PE result.
module pe_uop_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_x_base,
  input  logic [ADDR_W-1:0] cmd_w_base,
  input  logic [ADDR_W-1:0] cmd_bias_addr,
  input  logic              cmd_bias_en,
  input  logic              cmd_relu_en,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_rd_addr,
  input  logic [DATA_W-1:0] x_rd_data,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic [DATA_W-1:0] w_rd_data,
  output logic [DATA_W-1:0] pe_x,
  output logic [DATA_W-1:0] pe_weight,
  output logic              pe_flush,
  output logic              pe_in_valid,
  output logic              pe_calc_bias,
  output logic              pe_out_en,
  output logic              pe_calc_relu,
  input  logic [DATA_W-1:0] pe_result,
  input  logic              pe_out_valid,
  input  logic              pe_illegal_uop,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_ISSUE, S_DRAIN, S_WAIT, S_OUT
  } state_t;

  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t r_state, w_state_nxt;

  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_x_base, r_w_base, r_bias_addr;
  logic              r_bias_en, r_relu_en;
  logic [LEN_W:0]    r_rd_idx;
  logic              r_vld_p1, r_bias_p1, r_last_p1, r_oeo_p1;
  logic [DATA_W-1:0] r_res;
  logic              r_err;

  logic [LEN_W:0]    w_n;
  logic              w_issue, w_is_mac, w_last, w_accept;

  function automatic logic [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] v,
                                                input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  // Total reads for the window: K MAC terms plus the bias fetch when enabled.
  assign w_n      = {1'b0, r_len} + {{LEN_W{1'b0}}, r_bias_en};
  assign w_issue  = (r_state == S_FLUSH || r_state == S_ISSUE) && (r_rd_idx < w_n);
  assign w_is_mac = r_rd_idx < {1'b0, r_len};
  assign w_last   = (r_rd_idx == w_n - ONE);
  assign w_accept = cmd_valid && cmd_ready;

  assign x_rd_en   = w_issue && w_is_mac;
  assign w_rd_en   = w_issue;
  assign x_rd_addr = x_rd_en ? r_x_base + ADDR_W'(r_rd_idx) : '0;
  assign w_rd_addr = !w_rd_en ? '0 :
                     w_is_mac ? r_w_base + ADDR_W'(r_rd_idx) : r_bias_addr;

  assign pe_x         = x_rd_data;
  assign pe_weight    = w_rd_data;
  assign pe_calc_relu = 1'b0;
  assign pe_in_valid  = r_vld_p1;
  assign pe_calc_bias = r_vld_p1 && r_bias_p1;
  assign pe_out_en    = (r_vld_p1 && r_last_p1) || r_oeo_p1;
  assign res_data     = r_res;
  assign err          = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    pe_flush    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        pe_flush    = 1'b1;
        w_state_nxt = (w_n <= ONE) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: if (w_last) w_state_nxt = S_DRAIN;
      // With nothing to accumulate the result is known to be zero; skip the PE round trip.
      S_DRAIN: w_state_nxt = (w_n == '0) ? S_OUT : S_WAIT;
      S_WAIT:  if (pe_out_valid) w_state_nxt = S_OUT;
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage 0: command capture and read issue
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_len       <= cmd_len;
      r_x_base    <= cmd_x_base;
      r_w_base    <= cmd_w_base;
      r_bias_addr <= cmd_bias_addr;
      r_bias_en   <= cmd_bias_en;
      r_relu_en   <= cmd_relu_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_rd_idx <= '0;
    else if (w_accept) r_rd_idx <= '0;
    else if (w_issue)  r_rd_idx <= r_rd_idx + ONE;
  end

  // Stage 1: uop delivery aligned with returning buffer data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_bias_p1 <= 1'b0;
      r_last_p1 <= 1'b0;
      r_oeo_p1  <= 1'b0;
    end else begin
      r_vld_p1  <= w_issue;
      r_bias_p1 <= w_issue && !w_is_mac;
      r_last_p1 <= w_issue && w_last;
      r_oeo_p1  <= (r_state == S_FLUSH) && (w_n == '0);
    end
  end

  // Stage 2: result capture
  always_ff @(posedge clk) begin
    if (rst)
      r_res <= '0;
    else if (r_state == S_DRAIN && w_n == '0)
      r_res <= '0;
    else if (r_state == S_WAIT && pe_out_valid)
      r_res <= relu_fn(pe_result, r_relu_en);
  end

  always_ff @(posedge clk) begin
    if (rst)                 r_err <= 1'b0;
    else if (pe_illegal_uop) r_err <= 1'b1;
  end

endmodule
